// File: rtl/vga_pkg.sv
// Shared VGA definitions: pattern mode encoding, default 1366x768 timing, box-motion helper.
// Pure declarations; no timing or backpressure implications.
package vga_pkg;

  localparam int CNT_W = 12;

  typedef enum logic [1:0] {
    MODE_BARS  = 2'd0,
    MODE_CHECK = 2'd1,
    MODE_GRAD  = 2'd2,
    MODE_BOX   = 2'd3
  } mode_e;

  localparam int DEF_H_ACTIVE = 1366;
  localparam int DEF_H_FP     = 14;
  localparam int DEF_H_SYNC   = 56;
  localparam int DEF_H_BP     = 64;
  localparam int DEF_V_ACTIVE = 768;
  localparam int DEF_V_FP     = 1;
  localparam int DEF_V_SYNC   = 3;
  localparam int DEF_V_BP     = 28;

  // One bounce step: returns {fwd_next, pos_next}; a zero-width range pins the box.
  function automatic logic [CNT_W:0] box_step(input logic [CNT_W-1:0] pos,
                                              input logic             fwd,
                                              input logic [CNT_W-1:0] lim);
    logic [CNT_W-1:0] nxt;
    logic             nfwd;
    nxt  = fwd ? pos + 1'b1 : pos - 1'b1;
    nfwd = fwd;
    if (fwd && (nxt == lim)) begin
      nfwd = 1'b0;
    end else if (!fwd && (nxt == '0)) begin
      nfwd = 1'b1;
    end
    if (lim == '0) begin
      nxt  = pos;
      nfwd = fwd;
    end
    return {nfwd, nxt};
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Raster counters with combinational sync/de decode of the current counter position.
// Zero latency (decode follows counters); free-running, no backpressure.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic             clk_pix,
  input  logic             rst_n,
  output logic [CNT_W-1:0] sx,
  output logic [CNT_W-1:0] sy,
  output logic             hs_act,
  output logic             vs_act,
  output logic             de,
  output logic             line_end,
  output logic             frame_end
);

  localparam logic [CNT_W-1:0] LINE   = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_W-1:0] SCREEN = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [CNT_W-1:0] HA     = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] VA     = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  assign line_end  = (sx == LINE);
  assign frame_end = line_end && (sy == SCREEN);

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      sx <= '0;
      sy <= '0;
    end else if (line_end) begin
      sx <= '0;
      sy <= frame_end ? '0 : sy + 1'b1;
    end else begin
      sx <= sx + 1'b1;
    end
  end

  assign hs_act = (sx >= HS_BEG) && (sx <= HS_END);
  assign vs_act = (sy >= VS_BEG) && (sy <= VS_END);
  assign de     = (sx < HA) && (sy < VA);

endmodule

// File: rtl/vga_pattern_gen.sv
// Test-pattern generator: bars / checker / gradient / bouncing box over a parameterised raster.
// All outputs registered 1 cycle after their counter value; free-running, no backpressure.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter bit HS_POL     = 1'b1,
  parameter bit VS_POL     = 1'b1,
  parameter int COLOR_W    = 1,
  parameter int BOX_SIZE   = 64,
  parameter int CHECK_LOG2 = 5
) (
  input  logic               clk_pix,
  input  logic               rst_n,
  input  logic [1:0]         mode,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic [COLOR_W-1:0] vga_r,
  output logic [COLOR_W-1:0] vga_g,
  output logic [COLOR_W-1:0] vga_b,
  output logic [11:0]        sx_o,
  output logic [11:0]        sy_o,
  output logic               frame_start,
  output logic [15:0]        frame_cnt
);

  localparam int               BAR_W    = H_ACTIVE / 8;
  localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(BAR_W - 1);
  localparam logic [CNT_W-1:0] BX_MAX   = CNT_W'(H_ACTIVE - BOX_SIZE);
  localparam logic [CNT_W-1:0] BY_MAX   = CNT_W'(V_ACTIVE - BOX_SIZE);
  localparam logic [CNT_W:0]   BOX_EXT  = (CNT_W+1)'(BOX_SIZE);
  localparam logic [COLOR_W-1:0] FULL   = '1;

  logic [CNT_W-1:0] sx, sy;
  logic             hs_act, vs_act, de_c, line_end, frame_end;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk_pix   (clk_pix),
    .rst_n     (rst_n),
    .sx        (sx),
    .sy        (sy),
    .hs_act    (hs_act),
    .vs_act    (vs_act),
    .de        (de_c),
    .line_end  (line_end),
    .frame_end (frame_end)
  );

  // Bar index tracks sx without a divider; saturating at 7 lets the last bar absorb the remainder.
  logic [CNT_W-1:0] bar_pos;
  logic [2:0]       bar_idx;

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      bar_pos <= '0;
      bar_idx <= '0;
    end else if (line_end) begin
      bar_pos <= '0;
      bar_idx <= '0;
    end else if (bar_pos == BAR_LAST) begin
      bar_pos <= '0;
      if (bar_idx != 3'd7) bar_idx <= bar_idx + 3'd1;
    end else begin
      bar_pos <= bar_pos + 1'b1;
    end
  end

  // Frame-boundary state: mode latch, box motion and frame counter all change together.
  mode_e            mode_q;
  logic [CNT_W-1:0] bx, by;
  logic             bx_fwd, by_fwd;

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= MODE_BARS;
      bx        <= '0;
      by        <= '0;
      bx_fwd    <= 1'b1;
      by_fwd    <= 1'b1;
      frame_cnt <= '0;
    end else if (frame_end) begin
      mode_q           <= mode_e'(mode);
      {bx_fwd, bx}     <= box_step(bx, bx_fwd, BX_MAX);
      {by_fwd, by}     <= box_step(by, by_fwd, BY_MAX);
      frame_cnt        <= frame_cnt + 16'd1;
    end
  end

  logic [CNT_W:0] bx_end, by_end;
  logic           in_box;

  assign bx_end = {1'b0, bx} + BOX_EXT;
  assign by_end = {1'b0, by} + BOX_EXT;
  assign in_box = (sx >= bx) && ({1'b0, sx} < bx_end) &&
                  (sy >= by) && ({1'b0, sy} < by_end);

  logic [COLOR_W-1:0] pix_r, pix_g, pix_b;

  always_comb begin
    pix_r = '0;
    pix_g = '0;
    pix_b = '0;
    if (de_c) begin
      case (mode_q)
        MODE_BARS: begin
          pix_r = {COLOR_W{bar_idx[2]}};
          pix_g = {COLOR_W{bar_idx[1]}};
          pix_b = {COLOR_W{bar_idx[0]}};
        end
        MODE_CHECK: begin
          if (sx[CHECK_LOG2] ^ sy[CHECK_LOG2]) begin
            pix_r = FULL;
            pix_g = FULL;
            pix_b = FULL;
          end
        end
        MODE_GRAD: begin
          pix_r = sx[COLOR_W-1:0];
          pix_g = sx[COLOR_W-1:0];
          pix_b = sx[COLOR_W-1:0];
        end
        MODE_BOX: begin
          pix_b = FULL;
          if (in_box) begin
            pix_r = FULL;
            pix_g = FULL;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      de          <= 1'b0;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      sx_o        <= '0;
      sy_o        <= '0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= hs_act ? HS_POL : ~HS_POL;
      vsync       <= vs_act ? VS_POL : ~VS_POL;
      de          <= de_c;
      vga_r       <= pix_r;
      vga_g       <= pix_g;
      vga_b       <= pix_b;
      sx_o        <= sx;
      sy_o        <= sy;
      frame_start <= (sx == '0) && (sy == '0);
    end
  end

endmodule
